hwag_ign_channel: RTL

HWAG_IGN_CHANNEL -- requirements
Module: hwag_ign_channel

---
 rtl/hwag_ign_channel.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/hwag_ign_channel.sv
// Ignition coil channel: dwells between an on-angle and an off-angle of the crank cycle.
// Optional dwell-time limit enabled by defining HWAG_IGN_DWELL_LIMIT_EN.
module hwag_ign_channel #(
    parameter int unsigned ANGLE_TOP = 3839,
    parameter int unsigned AW        = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hwag_start,
    input  logic [AW-1:0] acnt,
    input  logic          ena,
    input  logic [AW-1:0] on_angle,
    input  logic [AW-1:0] off_angle,
    input  logic          cfg_wr,
    input  logic [23:0]   max_dwell,
    output logic          coil,
    output logic          spark,
    output logic          dwell_fault,
    output logic          cfg_err
);

    localparam int unsigned   DW  = 24;
    localparam logic [AW-1:0] TOP = AW'(ANGLE_TOP);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ON,
        DWELL
    } state_e;

    state_e        state_q;
    logic [AW-1:0] sh_on_q, sh_off_q;
    logic [AW-1:0] act_on_q, act_off_q;
    logic [AW-1:0] act_on_d, act_off_d;
    logic          prev_zero_q;
    logic          coil_q, spark_q, dwell_fault_q, cfg_err_q;
    logic          run_c, wrap_c, on_hit_c, off_hit_c, limit_hit_c;

    // Angle compares; out-of-range angles can never match, on==off never arms.
    always_comb begin
        run_c     = hwag_start && ena;
        wrap_c    = (acnt == '0) && !prev_zero_q;
        on_hit_c  = (acnt == act_on_q) && (act_on_q != act_off_q) && (act_on_q <= TOP);
        off_hit_c = (acnt == act_off_q) && (act_off_q <= TOP);
    end

    // Shadow-to-active copy at channel start, or on a crank wrap while waiting.
    always_comb begin
        act_on_d  = act_on_q;
        act_off_d = act_off_q;
        if (run_c && ((state_q == IDLE) || ((state_q == WAIT_ON) && wrap_c))) begin
            act_on_d  = sh_on_q;
            act_off_d = sh_off_q;
        end
    end

`ifdef HWAG_IGN_DWELL_LIMIT_EN
    logic [DW-1:0] dcnt_q;

    // Held at zero outside DWELL so each dwell starts counting from 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dcnt_q <= '0;
        end else if (state_q != DWELL) begin
            dcnt_q <= '0;
        end else begin
            dcnt_q <= dcnt_q + DW'(1);
        end
    end

    assign limit_hit_c = (max_dwell != '0) && (dcnt_q == (max_dwell - DW'(1)));
`else
    logic unused_max_dwell;
    assign unused_max_dwell = ^max_dwell;
    assign limit_hit_c      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            sh_on_q       <= '0;
            sh_off_q      <= '0;
            act_on_q      <= '0;
            act_off_q     <= '0;
            prev_zero_q   <= 1'b1;
            coil_q        <= 1'b0;
            spark_q       <= 1'b0;
            dwell_fault_q <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            prev_zero_q   <= (acnt == '0);
            act_on_q      <= act_on_d;
            act_off_q     <= act_off_d;
            cfg_err_q     <= (act_on_d > TOP) || (act_off_d > TOP);
            spark_q       <= 1'b0;
            dwell_fault_q <= 1'b0;
            if (cfg_wr) begin
                sh_on_q  <= on_angle;
                sh_off_q <= off_angle;
            end
            case (state_q)
                IDLE: begin
                    coil_q <= 1'b0;
                    if (run_c) state_q <= WAIT_ON;
                end
                WAIT_ON: begin
                    if (!run_c) begin
                        state_q <= IDLE;
                    end else if (on_hit_c) begin
                        state_q <= DWELL;
                        coil_q  <= 1'b1;
                    end
                end
                DWELL: begin
                    if (!run_c) begin
                        state_q <= IDLE;
                        coil_q  <= 1'b0;
                    end else if (off_hit_c) begin
                        state_q <= WAIT_ON;
                        coil_q  <= 1'b0;
                        spark_q <= 1'b1;
                    end else if (limit_hit_c) begin
                        state_q       <= WAIT_ON;
                        coil_q        <= 1'b0;
                        dwell_fault_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    coil_q  <= 1'b0;
                end
            endcase
        end
    end

    assign coil        = coil_q;
    assign spark       = spark_q;
    assign dwell_fault = dwell_fault_q;
    assign cfg_err     = cfg_err_q;

endmodule
